// File: rtl/p_hit_sched.sv
// p_hit_sched -- issue/retire scheduler in front of the p_hit intersection unit.
//
// Pops jobs from a show-ahead job FIFO and writes their operands into the four
// p_hit input FIFOs in one cycle. The job tag is held in an internal tag FIFO
// until the matching result comes back. Results return in order from the p_hit
// result FIFO. Each result is paired with its tag and presented on a one-entry
// output register for the consumer.
//
// Parameters
//   MAX_INFLIGHT  max jobs issued and not yet retired (power of 2, 2..256)
//   ID_WIDTH      job tag width
//
// Ports
//   clock, reset              single clock, synchronous active-high reset
//   enable, flush             issue permit / stop-issue-and-drain request
//   flush_done                one-cycle pulse when the drain completes
//   job_*                     upstream job FIFO (show-ahead) and operands
//   ph_* operands, ph_wr_en   p_hit input FIFO write side (all four together)
//   ph_full                   p_hit input FIFO full flags
//   ph_out, ph_empty, ph_rd_en  p_hit result FIFO read side
//   out_point, out_id, out_empty, out_rd_en  tagged result to consumer
//   inflight                  jobs issued and not yet retired
//   issued_cnt, retired_cnt   statistics counters
//
// Configuration macro: P_HIT_SCHED_STATS_EN
//   defined   -> issued_cnt/retired_cnt count issues/retires (wrap at 2^32)
//   undefined -> both ports tied to 0, no counter logic

module p_hit_sched #(
  parameter int MAX_INFLIGHT = 16,
  parameter int ID_WIDTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  output logic                          flush_done,
  input  logic                          job_empty,
  output logic                          job_rd_en,
  input  logic [2:0][31:0]              job_normal_1,
  input  logic [2:0][31:0]              job_normal_2,
  input  logic [2:0][31:0]              job_v0,
  input  logic [2:0][31:0]              job_origin,
  input  logic [2:0][31:0]              job_dir,
  input  logic [ID_WIDTH-1:0]           job_id,
  output logic [2:0][31:0]              ph_tri_normal_1,
  output logic [2:0][31:0]              ph_tri_normal_2,
  output logic [2:0][31:0]              ph_v0,
  output logic [2:0][31:0]              ph_origin_1,
  output logic [2:0][31:0]              ph_origin_2,
  output logic [2:0][31:0]              ph_dir_1,
  output logic [2:0][31:0]              ph_dir_2,
  output logic [3:0]                    ph_wr_en,
  input  logic [3:0]                    ph_full,
  input  logic [2:0][31:0]              ph_out,
  input  logic                          ph_empty,
  output logic                          ph_rd_en,
  output logic [2:0][31:0]              out_point,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_empty,
  input  logic                          out_rd_en,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic [31:0]                   issued_cnt,
  output logic [31:0]                   retired_cnt
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                issue, retire, tags_avail;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [ID_WIDTH-1:0] tag_mem [MAX_INFLIGHT];

  // ---------------------------------------------------------------------------
  // Operand passthrough: p_hit sees the show-ahead job data directly, so the
  // write strobes and the data are aligned in the same cycle.
  // ---------------------------------------------------------------------------
  assign ph_tri_normal_1 = job_normal_1;
  assign ph_tri_normal_2 = job_normal_2;
  assign ph_v0           = job_v0;
  assign ph_origin_1     = job_origin;
  assign ph_origin_2     = job_origin;
  assign ph_dir_1        = job_dir;
  assign ph_dir_2        = job_dir;

  // ---------------------------------------------------------------------------
  // Handshakes. inflight doubles as the tag FIFO occupancy. A result with no
  // tag outstanding is a protocol error upstream and is never popped.
  // Both strobes are held low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign tags_avail = (inflight != '0);

  assign issue  = !reset && (state_q == S_RUN) && !flush && !job_empty &&
                  (ph_full == 4'b0000) && (inflight < MAX_CNT);

  assign retire = !reset && !ph_empty && tags_avail && (out_empty || out_rd_en);

  assign job_rd_en = issue;
  assign ph_wr_en  = {4{issue}};
  assign ph_rd_en  = retire;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE:  if (enable && !flush) state_d = S_RUN;
      S_RUN:   if (flush || !enable) state_d = S_DRAIN;
      S_DRAIN: begin
        // Drained only when nothing is in p_hit and the consumer took the
        // last result.
        if ((inflight == '0) && out_empty) begin
          state_d    = S_IDLE;
          flush_done = !reset;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO. Depth is a power of two so the pointers wrap naturally.
  // Storage is not reset; pointers and occupancy define validity.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (issue) tag_mem[wr_ptr] <= job_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (issue)  wr_ptr <= wr_ptr + AW'(1);
      if (retire) rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous issue and retire leave occupancy unchanged.
      if (issue && !retire)      inflight <= inflight + CW'(1);
      else if (retire && !issue) inflight <= inflight - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A retire may overwrite the entry in the same cycle the
  // consumer reads it, so back-to-back results stream at full rate.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      out_point <= '0;
      out_id    <= '0;
      out_empty <= 1'b1;
    end else if (retire) begin
      out_point <= ph_out;
      out_id    <= tag_mem[rd_ptr];
      out_empty <= 1'b0;
    end else if (out_rd_en) begin
      out_empty <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef P_HIT_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_cnt  <= '0;
      retired_cnt <= '0;
    end else begin
      if (issue)  issued_cnt  <= issued_cnt + 32'd1;
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`else
  assign issued_cnt  = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_p_hit_sched.sv
// Directed bench for p_hit_sched. It drives a job FIFO stub and a p_hit stub
// that returns each job's origin as its result one cycle after issue. A
// queue-based model of the scheduling rules is checked against the DUT every
// cycle. Hand-computed literal checks pin the key scenarios.
module tb_p_hit_sched;
  localparam int MAXI = 16;
  localparam int IDW  = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
`ifdef P_HIT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, flush = 1'b0;
  logic flush_done, job_rd_en, ph_rd_en, out_empty;
  logic job_empty = 1'b1, ph_empty = 1'b1, out_rd_en = 1'b0;
  logic [2:0][31:0] job_normal_1 = '0, job_normal_2 = '0, job_v0 = '0;
  logic [2:0][31:0] job_origin = '0, job_dir = '0, ph_out = '0;
  logic [IDW-1:0] job_id = '0, out_id;
  logic [2:0][31:0] ph_tri_normal_1, ph_tri_normal_2, ph_v0;
  logic [2:0][31:0] ph_origin_1, ph_origin_2, ph_dir_1, ph_dir_2, out_point;
  logic [3:0] ph_wr_en, ph_full = 4'b0000;
  logic [$clog2(MAXI):0] inflight;
  logic [31:0] issued_cnt, retired_cnt;

  p_hit_sched #(.MAX_INFLIGHT(MAXI), .ID_WIDTH(IDW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .flush_done(flush_done), .job_empty(job_empty), .job_rd_en(job_rd_en),
    .job_normal_1(job_normal_1), .job_normal_2(job_normal_2), .job_v0(job_v0),
    .job_origin(job_origin), .job_dir(job_dir), .job_id(job_id),
    .ph_tri_normal_1(ph_tri_normal_1), .ph_tri_normal_2(ph_tri_normal_2),
    .ph_v0(ph_v0), .ph_origin_1(ph_origin_1), .ph_origin_2(ph_origin_2),
    .ph_dir_1(ph_dir_1), .ph_dir_2(ph_dir_2), .ph_wr_en(ph_wr_en),
    .ph_full(ph_full), .ph_out(ph_out), .ph_empty(ph_empty), .ph_rd_en(ph_rd_en),
    .out_point(out_point), .out_id(out_id), .out_empty(out_empty),
    .out_rd_en(out_rd_en), .inflight(inflight), .issued_cnt(issued_cnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  // environment
  typedef struct { logic [IDW-1:0] id; logic [95:0] org; } job_t;
  job_t        jq[$];
  logic [95:0] phq[$];
  bit          hold = 1'b0;   // keep the p_hit result FIFO looking empty

  // model
  int             m_mode;
  logic [IDW-1:0] m_tags[$];
  bit             m_oval;
  logic [95:0]    m_pt;
  logic [IDW-1:0] m_id;
  int             m_iss, m_ret;

  function automatic void chk(string nm, logic [383:0] a, logic [383:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endfunction

  function automatic logic [95:0] mk_org(logic [IDW-1:0] id);
    return {id, 16'h3, id, 16'h2, id, 16'h1};
  endfunction

  function automatic void drive_env();
    job_empty = (jq.size() == 0);
    if (jq.size() != 0) begin
      job_id     = jq[0].id;
      job_origin = jq[0].org;
      for (int i = 0; i < 3; i++) begin
        job_normal_1[i] = {jq[0].id, 16'(i)};
        job_normal_2[i] = {16'(i + 4), jq[0].id};
        job_v0[i]       = ~{jq[0].id, 16'(i)};
        job_dir[i]      = {jq[0].id, 16'(i + 8)};
      end
    end else begin
      job_id = '0; job_origin = '0; job_normal_1 = '0;
      job_normal_2 = '0; job_v0 = '0; job_dir = '0;
    end
    ph_empty = hold || (phq.size() == 0);
    ph_out   = (phq.size() != 0) ? phq[0] : '0;
  endfunction

  function automatic void push_job(logic [IDW-1:0] id, logic [95:0] org);
    job_t j;
    j.id = id; j.org = org;
    jq.push_back(j);
    drive_env();
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_tags.delete(); m_oval = 1'b0;
    m_pt = '0; m_id = '0; m_iss = 0; m_ret = 0;
  endfunction

  task automatic check_and_step();
    bit e_iss, e_ret, e_fd;
    e_iss = (m_mode == M_RUN) && !flush && !job_empty && (ph_full == 4'b0000) &&
            (m_tags.size() < MAXI);
    e_ret = !ph_empty && (m_tags.size() != 0) && (!m_oval || out_rd_en);
    e_fd  = (m_mode == M_DRAIN) && (m_tags.size() == 0) && !m_oval;
    chk("job_rd_en", job_rd_en, e_iss);
    chk("ph_wr_en", ph_wr_en, {4{e_iss}});
    chk("ph_rd_en", ph_rd_en, e_ret);
    chk("flush_done", flush_done, e_fd);
    chk("inflight", inflight, m_tags.size());
    chk("out_empty", out_empty, !m_oval);
    chk("out_point", out_point, m_pt);
    chk("out_id", out_id, m_id);
    chk("issued_cnt", issued_cnt, STATS ? m_iss : 0);
    chk("retired_cnt", retired_cnt, STATS ? m_ret : 0);
    if (e_iss) begin
      chk("ph_operands", {ph_tri_normal_1, ph_tri_normal_2, ph_v0},
          {job_normal_1, job_normal_2, job_v0});
      chk("ph_geom", {ph_origin_1, ph_origin_2, ph_dir_1, ph_dir_2},
          {job_origin, job_origin, job_dir, job_dir});
    end
    // model advance
    if (e_ret) begin
      m_oval = 1'b1; m_pt = ph_out; m_id = m_tags.pop_front(); m_ret++;
    end else if (out_rd_en) begin
      m_oval = 1'b0;
    end
    if (e_iss) begin
      m_tags.push_back(job_id); m_iss++;
    end
    case (m_mode)
      M_IDLE:  if (enable && !flush) m_mode = M_RUN;
      M_RUN:   if (flush || !enable) m_mode = M_DRAIN;
      default: if (e_fd) m_mode = M_IDLE;
    endcase
    // environment reacts to what the DUT actually did
    if (job_rd_en && jq.size() != 0) void'(jq.pop_front());
    if (ph_wr_en == 4'hf) phq.push_back(job_origin);
    if (ph_rd_en && phq.size() != 0) void'(phq.pop_front());
  endtask

  task automatic tick();
    @(negedge clock);
    if (reset) model_reset();
    else       check_and_step();
    @(posedge clock);
    #1;
    drive_env();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; hold = 1'b0;
    out_rd_en = 1'b0; ph_full = 4'b0000;
    jq.delete(); phq.delete();
    drive_env();
    ticks(2);
    reset = 1'b0;
    drive_env();
  endtask

  logic [IDW-1:0] got[$];
  int pulses, at_pulse;

  initial begin
    model_reset();
    // ---- reset state and a single job round trip
    do_reset();
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_out_empty", out_empty, 1);
    chk("rst_out_point", out_point, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_hs", {job_rd_en, ph_wr_en, ph_rd_en, flush_done}, 0);
    chk("rst_cnt", {issued_cnt, retired_cnt}, 0);
    enable = 1'b1;
    tick();
    push_job(16'h0005, {32'h0003_0000, 32'h0002_0000, 32'h0001_0000});
    #1;
    chk("one_rd_en", job_rd_en, 1);
    chk("one_wr_en", ph_wr_en, 4'b1111);
    tick();
    chk("one_inflight", inflight, 1);
    #1;
    chk("one_ph_rd", ph_rd_en, 1);
    tick();
    chk("one_out_empty", out_empty, 0);
    chk("one_pt0", out_point[0], 32'h0001_0000);
    chk("one_pt1", out_point[1], 32'h0002_0000);
    chk("one_pt2", out_point[2], 32'h0003_0000);
    chk("one_id", out_id, 16'h0005);
    out_rd_en = 1'b1;
    tick();
    chk("one_consumed", out_empty, 1);
    out_rd_en = 1'b0;

    // ---- a single full bit blocks issue entirely
    ph_full = 4'b0100;
    push_job(16'h0011, mk_org(16'h0011));
    #1;
    chk("full_rd_en", job_rd_en, 0);
    chk("full_wr_en", ph_wr_en, 4'b0000);
    ticks(3);
    ph_full = 4'b0000;
    #1;
    chk("unfull_rd_en", job_rd_en, 1);
    out_rd_en = 1'b1;
    ticks(5);
    out_rd_en = 1'b0;

    // ---- inflight limit
    do_reset();
    enable = 1'b1; hold = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) push_job(16'h0100 + 16'(i), mk_org(16'h0100 + 16'(i)));
    ticks(25);
    chk("lim_inflight", inflight, 16);
    chk("lim_left", jq.size(), 4);
    #1;
    chk("lim_stall", job_rd_en, 0);

    // ---- reset with jobs in flight discards them
    do_reset();
    #1;
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_out_empty", out_empty, 1);

    // ---- issue and retire together keep inflight
    enable = 1'b1; hold = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push_job(16'h0200 + 16'(i), mk_org(16'h0200 + 16'(i)));
    ticks(5);
    chk("both_pre", inflight, 3);
    push_job(16'h0203, mk_org(16'h0203));
    hold = 1'b0; out_rd_en = 1'b1;
    drive_env();
    #1;
    chk("both_rd_en", job_rd_en, 1);
    chk("both_ph_rd", ph_rd_en, 1);
    tick();
    chk("both_inflight", inflight, 3);
    ticks(10);
    chk("both_drained", inflight, 0);

    // ---- flush with 4 in flight
    do_reset();
    enable = 1'b1; hold = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_job(16'h0020 + 16'(i), mk_org(16'h0020 + 16'(i)));
    ticks(6);
    chk("fl_pre", inflight, 4);
    push_job(16'h0024, mk_org(16'h0024));
    push_job(16'h0025, mk_org(16'h0025));
    flush = 1'b1; out_rd_en = 1'b1; hold = 1'b0;
    drive_env();
    got.delete(); pulses = 0; at_pulse = -1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (!out_empty) got.push_back(out_id);
      if (flush_done) begin pulses++; at_pulse = got.size(); end
      tick();
    end
    chk("fl_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("fl_order", got[i], 16'h0020 + 16'(i));
    chk("fl_pulses", pulses, 1);
    chk("fl_after_last", at_pulse, 4);
    chk("fl_no_issue", jq.size(), 2);
    chk("fl_inflight", inflight, 0);
    flush = 1'b0;
    ticks(10);
    chk("fl_resume", jq.size(), 0);

    // ---- ten jobs completed, statistics
    do_reset();
    enable = 1'b1; out_rd_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) push_job(16'h0300 + 16'(i), mk_org(16'h0300 + 16'(i)));
    ticks(30);
    chk("st_issued", issued_cnt, STATS ? 10 : 0);
    chk("st_retired", retired_cnt, STATS ? 10 : 0);
    chk("st_inflight", inflight, 0);
    chk("st_out_empty", out_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/p_hit_sched.md
P_HIT_SCHED -- requirements
Module: p_hit_sched

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 16: max jobs issued to p_hit and not yet retired (power of 2, 2..256).
REQ-002 SHALL have parameter ID_WIDTH, default 16: job tag width.
REQ-003 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  level; permits issue.
REQ-006 SHALL have port flush  in  1  level; stop issue and drain.
REQ-007 SHALL have port flush_done  out  1  one-cycle pulse when drain completes.
REQ-008 SHALL have port job_empty  in  1  upstream job FIFO empty (show-ahead data).
REQ-009 SHALL have port job_rd_en  out  1  pops upstream job FIFO.
REQ-010 SHALL have ports job_normal_1[2:0], job_normal_2[2:0], job_v0[2:0], job_origin[2:0], job_dir[2:0]  in  32 each, signed Q16  job operands.
REQ-011 SHALL have port job_id  in  ID_WIDTH  job tag.
REQ-012 SHALL have ports ph_tri_normal_1/2, ph_v0, ph_origin_1/2, ph_dir_1/2 [2:0]  out  32 each  operands to p_hit; origin_1/2 both from job_origin, dir_1/2 both from job_dir.
REQ-013 SHALL have port ph_wr_en[3:0]  out  1 each; ph_full[3:0]  in  1 each  p_hit input FIFO handshake.
REQ-014 SHALL have ports ph_out[2:0]  in  32; ph_empty  in  1; ph_rd_en  out  1  p_hit result FIFO.
REQ-015 SHALL have ports out_point[2:0]  out  32; out_id  out  ID_WIDTH; out_empty  out  1; out_rd_en  in  1  tagged result to consumer.
REQ-016 SHALL have ports inflight  out  clog2(MAX_INFLIGHT)+1; issued_cnt, retired_cnt  out  32 each.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN when enable=1 and flush=0; RUN->DRAIN when flush=1 or enable=0; DRAIN->IDLE when inflight==0 and out_empty==1, pulsing flush_done that cycle.
REQ-018 SHALL issue only in RUN when flush=0, job_empty=0, all ph_full bits 0, and inflight<MAX_INFLIGHT.
REQ-019 SHALL, on issue, assert job_rd_en and all four ph_wr_en bits combinationally in the same cycle, never a subset; ph operand ports SHALL pass job operands through combinationally.
REQ-020 SHALL push job_id into an internal tag FIFO of depth MAX_INFLIGHT on each issue.
REQ-021 SHALL retire when ph_empty=0 and (out_empty=1 or out_rd_en=1): assert ph_rd_en, pop tag FIFO, register ph_out and tag into out_point/out_id, clear out_empty next cycle.
REQ-022 SHALL set out_empty=1 the cycle after out_rd_en=1 with no concurrent retire; out_rd_en while out_empty=1 SHALL be ignored.
REQ-023 SHALL increment inflight on issue, decrement on retire, hold when both occur in one cycle.
REQ-024 SHALL keep retiring results in all states, including IDLE and DRAIN.
REQ-025 SHALL never assert ph_rd_en when tag FIFO empty; ph_empty=0 with inflight==0 is a protocol error and SHALL be ignored.

Reset
REQ-026 SHALL, on reset, force state IDLE, inflight 0, tag FIFO empty, out_empty 1, out_point/out_id 0, flush_done 0, counters 0, all handshake outputs 0; reset mid-operation discards in-flight tags.

Configuration
REQ-027 SHALL use macro P_HIT_SCHED_STATS_EN: defined -> issued_cnt/retired_cnt count issues/retires, wrapping at 2^32; undefined -> ports present, driven 0, no counter logic.

Verification
REQ-028 SHALL cover: reset, enable=1, one job id=0x0005 with ph_full=0 -> job_rd_en and ph_wr_en=4'b1111 same cycle, inflight=1; p_hit result (1.0,2.0,3.0) -> out_point=(0x10000,0x20000,0x30000), out_id=0x0005 one cycle later.
REQ-029 SHALL cover: ph_full=4'b0100 with job pending -> no job_rd_en, ph_wr_en=0 until bit clears.
REQ-030 SHALL cover: 20 jobs, ph_empty held 1, MAX_INFLIGHT=16 -> exactly 16 issues, inflight=16, issue stalls.
REQ-031 SHALL cover: issue and retire same cycle at inflight=3 -> inflight stays 3.
REQ-032 SHALL cover: flush=1 with inflight=4, out_rd_en held 1 -> no further issue, 4 results ids in order, flush_done single pulse after last, state IDLE.
REQ-033 SHALL cover: with P_HIT_SCHED_STATS_EN, 10 jobs completed -> issued_cnt=10, retired_cnt=10; without -> both 0.
